serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 27 ++
 rtl/bit_timer.sv | 40 ++++
 rtl/serial_tx.sv | 109 ++++++++++
 tb/tb_serial_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module  : serial_pkg
// Brief   : Shared types and defaults for the serial frame transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Transmitter phase: idle line, start bit, data bits, stop bit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_BIT_CYCLES = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/bit_timer.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module  : bit_timer
// Brief   : Free-running bit-period counter; tick marks the last cycle of
//           each BIT_CYCLES-long period. clr restarts the period.
// Revision: 1.0 - initial release
// ============================================================================
module bit_timer
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic CLK,
  input  logic n_res,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = width_of(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count 0..BIT_CYCLES-1 and wrap; clr aligns a new period to the accepting edge
  always_ff @(posedge CLK or negedge n_res) begin
    if (!n_res) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // With BIT_CYCLES=1 the counter sits at zero and tick is permanently high
  assign tick = (cnt == LAST);

endmodule : bit_timer
`default_nettype wire

// File: rtl/serial_tx.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module  : serial_tx
// Brief   : Parallel-in serial-out frame transmitter. Start bit (0), WIDTH
//           data bits LSB first, stop bit (1); each bit lasts BIT_CYCLES
//           clocks. valid/ready intake, one-cycle done pulse on completion.
// Revision: 1.0 - initial release
// ============================================================================
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic             CLK,
  input  logic             n_res,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             TX,
  output logic             busy,
  output logic             done
);

  localparam int            IW       = width_of(WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nx;
  logic [IW-1:0]    bit_idx;
  logic             accept;
  logic             tick;

  // ready is registered and only high in IDLE, so accept can only fire there
  assign accept   = valid && ready;
  assign shift_nx = shift >> 1;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .CLK  (CLK),
    .n_res(n_res),
    .clr  (accept),
    .tick (tick)
  );

  // Frame sequencer: every output is a register updated alongside the state
  always_ff @(posedge CLK or negedge n_res) begin
    if (!n_res) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      TX      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift   <= data_in;
            bit_idx <= '0;
            state   <= START;
            TX      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            TX    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              shift   <= shift_nx;
              TX      <= shift_nx[0];
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          TX    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_tx
`default_nettype wire

// File: tb/tb_serial_tx.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module  : tb_serial_tx
// Brief   : Scoreboard bench for serial_tx. Stimulus pushes expected words;
//           a line-receiver monitor rebuilds each frame from TX and pops.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_tx;

  logic       clk     = 1'b0;
  logic       n_res   = 1'b1;
  logic [7:0] data_a  = '0;
  logic [7:0] data_b  = '0;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  always #50 clk = ~clk;

  serial_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut_a (
    .CLK(clk), .n_res(n_res), .data_in(data_a), .valid(valid_a),
    .ready(ready_a), .TX(tx_a), .busy(busy_a), .done(done_a)
  );

  serial_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut_b (
    .CLK(clk), .n_res(n_res), .data_in(data_b), .valid(valid_b),
    .ready(ready_b), .TX(tx_b), .busy(busy_b), .done(done_b)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  // monitor state; sel chooses which instance the receiver listens to
  bit         sel    = 1'b0;
  bit         mon_en = 1'b0;
  bit         rx_active = 1'b0;
  int         cyc = 0, rx_pos = 0, body_bad = 0, bc = 4;
  int         frames = 0, done_seen = 0, start_prev = 0, start_last = 0;
  logic [9:0] rx_bits;
  logic [7:0] mon_w;
  logic       m_tx, m_busy, m_ready, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver: sample 10ps after each edge, start on a low line, take bits mid-period
  always @(posedge clk) begin
    #10;
    cyc++;
    m_tx    = sel ? tx_b    : tx_a;
    m_busy  = sel ? busy_b  : busy_a;
    m_ready = sel ? ready_b : ready_a;
    m_done  = sel ? done_b  : done_a;
    bc      = sel ? 1 : 4;
    if (!mon_en || !n_res) begin
      rx_active = 1'b0;
    end else begin
      if (m_done === 1'b1) done_seen++;
      if (!rx_active && m_tx === 1'b0) begin
        rx_active  = 1'b1;
        rx_pos     = 0;
        body_bad   = 0;
        rx_bits    = '1;
        start_prev = start_last;
        start_last = cyc;
      end
      if (rx_active) begin
        if (rx_pos < 10 * bc) begin
          if (m_busy !== 1'b1 || m_ready !== 1'b0 || m_done !== 1'b0) body_bad++;
          if ((rx_pos % bc) == (bc / 2)) rx_bits[rx_pos / bc] = m_tx;
          rx_pos++;
        end else begin
          check("frame_body_flags_bad_cycles", body_bad, 0);
          check("done_at_frame_end", {31'd0, m_done}, 1);
          check("idle_busy_ready_tx", {29'd0, m_busy, m_ready, m_tx}, 3'b011);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got %03h expected none", rx_bits);
          end else begin
            mon_w = exp_q.pop_front();
            check("frame_bits", {22'd0, rx_bits}, {22'd0, 1'b1, mon_w, 1'b0});
          end
          frames++;
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input string name);
    int k = 0;
    while (frames < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, frames >= target}, 1);
  endtask

  // One-cycle valid on the selected instance; leaves the bench just after acceptance
  task automatic send(input logic [7:0] w, input string name);
    @(negedge clk);
    if (sel) begin data_b = w; valid_b = 1'b1; end
    else     begin data_a = w; valid_a = 1'b1; end
    exp_q.push_back(w);
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    check(name, {31'd0, sel ? ready_b : ready_a}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, k;

    // 1: asynchronous reset between edges
    @(negedge clk);
    #10 n_res = 1'b0;
    #10;
    check("rst_a_tx_ready_busy_done", {28'd0, tx_a, ready_a, busy_a, done_a}, 4'b1100);
    check("rst_b_tx_ready_busy_done", {28'd0, tx_b, ready_b, busy_b, done_b}, 4'b1100);
    #5 n_res = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // 2: single frame 8'hA5
    send(8'hA5, "accept_A5");
    wait_frames(1, "frame_A5_timeout");
    check("done_count_A5", done_seen, 1);

    // 3: back-to-back with valid held high
    @(negedge clk);
    data_a = 8'h00; valid_a = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(negedge clk);
    check("b2b_accept_first", {31'd0, ready_a}, 0);
    data_a = 8'hFF;
    k = 0;
    while (ready_a !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    @(negedge clk);
    valid_a = 1'b0;
    check("b2b_accept_second", {31'd0, ready_a}, 0);
    wait_frames(3, "frame_b2b_timeout");
    check("b2b_start_spacing", start_last - start_prev, 41);
    check("done_count_b2b", done_seen, 3);

    // 4: valid while busy is ignored
    f0 = frames; d0 = done_seen;
    send(8'h0F, "accept_0F");
    wait_cycles(12);
    data_a = 8'h3C; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    wait_frames(f0 + 1, "frame_0F_timeout");
    wait_cycles(100);
    check("busy_ignore_frames", frames - f0, 1);
    check("busy_ignore_done", done_seen - d0, 1);
    check("busy_ignore_queue_empty", exp_q.size(), 0);

    // 5: reset in the middle of data bit 3
    f0 = frames; d0 = done_seen;
    send(8'hF0, "accept_F0");
    wait_cycles(17);
    #10 n_res = 1'b0;
    #10;
    check("midrst_tx_busy_ready_done", {28'd0, tx_a, busy_a, ready_a, done_a}, 4'b1010);
    exp_q.delete();
    @(negedge clk);
    n_res = 1'b1;
    wait_cycles(20);
    check("midrst_no_done", done_seen - d0, 0);
    check("midrst_no_frame", frames - f0, 0);
    send(8'h81, "accept_81");
    wait_frames(f0 + 1, "frame_81_timeout");

    // 6: one clock per bit
    @(negedge clk);
    sel = 1'b1;
    f0 = frames; d0 = done_seen;
    send(8'h5A, "accept_5A_bc1");
    wait_frames(f0 + 1, "frame_5A_timeout");
    check("done_count_5A", done_seen - d0, 1);
    check("final_queue_empty", exp_q.size(), 0);

    wait_cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_tx
`default_nettype wire
